button_seq_checker: RTL

//  Checks a player's button presses against a stored sequence of expected button codes, in order.

---
 rtl/button_seq_checker.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/button_seq_checker.sv
// Round judge: compares debounced one-hot button presses against a stored code sequence.
// Define BTN_TIMEOUT_EN to build the per-press timeout counter; otherwise timeout is tied low.
module button_seq_checker #(
  parameter int NBTN    = 8,
  parameter int CODE_W  = 4,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int SCORE_W = 8,
  parameter int TMO_CYC = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(MAX_LEN)-1:0] wr_addr,
  input  logic [CODE_W-1:0]          code_in,
  input  logic [LEN_W-1:0]           seq_len,
  input  logic                       start,
  input  logic [NBTN-1:0]            click,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       timeout,
  output logic [LEN_W-1:0]           step,
  output logic [SCORE_W-1:0]         score
);

  localparam int ADDR_W = $clog2(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REL,
    S_PRESS,
    S_PASS,
    S_FAIL
  } state_e;

  state_e state_q, state_d;

  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   step_q, step_d;
  logic [SCORE_W-1:0] score_q, score_d;

  logic [CODE_W-1:0]  store_q [MAX_LEN];
  logic               store_we;

  logic [CODE_W-1:0]  cur_code;
  logic               code_ok;
  logic [NBTN-1:0]    exp_mask;
  logic               any_click;
  logic               hit;
  logic               last;
  logic               len_ok;
  logic               expire;

  // Expected mask is one-hot by construction, so equality also rejects multi-button clicks.
  always_comb begin
    cur_code  = store_q[step_q[ADDR_W-1:0]];
    code_ok   = (cur_code != '0) && (cur_code <= CODE_W'(NBTN));
    exp_mask  = '0;
    if (code_ok) begin
      exp_mask = {{(NBTN-1){1'b0}}, 1'b1} << (cur_code - CODE_W'(1));
    end
    any_click = (click != '0);
    hit       = code_ok && (click == exp_mask);
    last      = (step_q == len_q - LEN_W'(1));
    len_ok    = (seq_len != '0) && (seq_len <= LEN_W'(MAX_LEN));
    store_we  = wr_en && (state_q == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (store_we) begin
      store_q[wr_addr] <= code_in;
    end
  end

`ifdef BTN_TIMEOUT_EN
  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  // Counter restarts on every entry to PRESS, since it idles at zero outside PRESS.
  always_comb begin
    cnt_d  = (state_q == S_PRESS) ? cnt_q + TMO_W'(1) : '0;
    expire = (cnt_q == TMO_W'(TMO_CYC - 1));
    tmo_d  = 1'b0;
    if (state_q == S_PRESS && !any_click && expire) begin
      tmo_d = 1'b1;
    end else if (state_q == S_FAIL) begin
      tmo_d = tmo_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout = tmo_q && (state_q == S_FAIL);
`else
  logic unused_tmo;

  assign unused_tmo = (TMO_CYC != 0);
  assign expire     = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      step_q  <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      step_q  <= step_d;
      score_q <= score_d;
    end
  end

  // A press is judged in the cycle it first appears; expiry only wins when nothing is pressed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = len_ok ? S_REL : S_FAIL;
        end
      end
      S_REL: begin
        if (!any_click) begin
          state_d = S_PRESS;
        end
      end
      S_PRESS: begin
        if (any_click) begin
          if (!hit) begin
            state_d = S_FAIL;
          end else if (last) begin
            state_d = S_PASS;
          end else begin
            state_d = S_REL;
          end
        end else if (expire) begin
          state_d = S_FAIL;
        end
      end
      S_PASS, S_FAIL: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    len_d   = len_q;
    step_d  = step_q;
    score_d = score_q;
    if (state_q == S_IDLE && start) begin
      len_d  = seq_len;
      step_d = '0;
    end
    if (state_q == S_PRESS && any_click && hit && !last) begin
      step_d = step_q + LEN_W'(1);
    end
    if (state_d == S_PASS && state_q != S_PASS && score_q != '1) begin
      score_d = score_q + SCORE_W'(1);
    end
  end

  always_comb begin
    busy  = (state_q == S_REL) || (state_q == S_PRESS);
    done  = (state_q == S_PASS) || (state_q == S_FAIL);
    pass  = (state_q == S_PASS);
    step  = step_q;
    score = score_q;
  end

endmodule
